// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, pipeline latency, the tag carried
// alongside each issued operation, and the opcode legality check.
package alu_pkg;

  localparam logic [3:0] ALU_OP_IDLE = 4'b0000;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0010;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0011;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1011;
  localparam logic [3:0] ALU_OP_AND  = 4'b0100;
  localparam logic [3:0] ALU_OP_OR   = 4'b0101;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0111;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1001;

  localparam int ALU_LAT = 2;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } alu_tag_t;

  // IDLE is deliberately not legal: a request carrying 0000 is an error.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_AND,
      ALU_OP_OR, ALU_OP_XOR, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between the two requesters, the ALU and
// the arbiter. The arbiter takes the slave view; the surrounding logic the master.
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic              REQ0_VALID, REQ1_VALID;
  logic              REQ0_READY, REQ1_READY;
  logic [3:0]        REQ0_OP, REQ1_OP;
  logic [DATA_W-1:0] REQ0_A, REQ1_A, REQ0_B, REQ1_B;
  logic [3:0]        ALU_OP_VAL;
  logic [DATA_W-1:0] ALU_A, ALU_B, ALU_OUT;
  logic              ALU_CARRY, ALU_ZERO, ALU_DONE;
  logic              RSP0_VALID, RSP1_VALID;
  logic [DATA_W-1:0] RSP_OUT;
  logic              RSP_CARRY, RSP_ZERO, RSP_ERR;

  modport slave (
    input  REQ0_VALID, REQ1_VALID, REQ0_OP, REQ1_OP, REQ0_A, REQ1_A, REQ0_B, REQ1_B,
    input  ALU_OUT, ALU_CARRY, ALU_ZERO, ALU_DONE,
    output REQ0_READY, REQ1_READY, ALU_OP_VAL, ALU_A, ALU_B,
    output RSP0_VALID, RSP1_VALID, RSP_OUT, RSP_CARRY, RSP_ZERO, RSP_ERR
  );

  modport master (
    output REQ0_VALID, REQ1_VALID, REQ0_OP, REQ1_OP, REQ0_A, REQ1_A, REQ0_B, REQ1_B,
    output ALU_OUT, ALU_CARRY, ALU_ZERO, ALU_DONE,
    input  REQ0_READY, REQ1_READY, ALU_OP_VAL, ALU_A, ALU_B,
    input  RSP0_VALID, RSP1_VALID, RSP_OUT, RSP_CARRY, RSP_ZERO, RSP_ERR
  );
endinterface

// File: rtl/alu_arb_tag_pipe.sv
// Shift register of operation tags that mirrors the ALU pipeline depth.
// A synchronous clear drops every in-flight tag (reset or flush).
module alu_arb_tag_pipe
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_LAT
) (
  input  logic     CK_REF,
  input  logic     clr,
  input  alu_tag_t tag_in,
  output alu_tag_t tag_tail
);

  alu_tag_t pipe_r [DEPTH];

  // Load stage 0 every cycle and advance older tags by one stage.
  always_ff @(posedge CK_REF) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign tag_tail = pipe_r[DEPTH-1];

endmodule

// File: rtl/alu_arbiter_chk.sv
// Consistency checker: a legal operation reaching the tag-pipe tail must meet
// a valid ALU result.
module alu_arbiter_chk (
  input logic CK_REF,
  input logic RST,
  input logic tail_valid,
  input logic tail_err,
  input logic ALU_DONE
);

  a_done_with_tail: assert property (@(posedge CK_REF) disable iff (RST)
    (tail_valid && !tail_err) |-> ALU_DONE);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one pipelined ALU between the execute stage (requester 0)
// and the branch/address unit (requester 1). Results are routed back using a
// tag that travels alongside each operation.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
  input logic          CK_REF,
  input logic          RST,
  input logic          FLUSH,
  alu_arbiter_if.slave bus
);

  logic              gnt0_s, gnt1_s;
  logic [3:0]        sel_op_s;
  logic [DATA_W-1:0] sel_a_s, sel_b_s;
  alu_tag_t          tag_in_s, tag_tail_s;
  logic              rsp_live_s;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // prio_r names the requester that wins a tie: the one not granted last,
  // requester 0 out of reset.
  logic prio_r;

  // Tie-break pointer, moved only when a grant is made.
  always_ff @(posedge CK_REF) begin
    if (RST)         prio_r <= 1'b0;
    else if (gnt0_s) prio_r <= 1'b1;
    else if (gnt1_s) prio_r <= 1'b0;
    else             prio_r <= prio_r;
  end
`endif

  // Grant decision: at most one requester per cycle, none during reset/flush.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (RST || FLUSH) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.REQ0_VALID && bus.REQ1_VALID) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      gnt0_s = !prio_r;
      gnt1_s = prio_r;
`else
      gnt0_s = 1'b1;
      gnt1_s = 1'b0;
`endif
    end else begin
      gnt0_s = bus.REQ0_VALID;
      gnt1_s = bus.REQ1_VALID;
    end
  end

  // Issue mux: drive the ALU from the granted requester; illegal opcodes
  // are accepted but leave the ALU idle and mark the tag as an error.
  always_comb begin
    sel_op_s = 4'b0000;
    sel_a_s  = '0;
    sel_b_s  = '0;
    if (gnt1_s) begin
      sel_op_s = bus.REQ1_OP;
      sel_a_s  = bus.REQ1_A;
      sel_b_s  = bus.REQ1_B;
    end else if (gnt0_s) begin
      sel_op_s = bus.REQ0_OP;
      sel_a_s  = bus.REQ0_A;
      sel_b_s  = bus.REQ0_B;
    end else begin
      sel_op_s = 4'b0000;
      sel_a_s  = '0;
      sel_b_s  = '0;
    end
    bus.REQ0_READY   = gnt0_s;
    bus.REQ1_READY   = gnt1_s;
    bus.ALU_OP_VAL   = is_legal_op(sel_op_s) ? sel_op_s : ALU_OP_IDLE;
    bus.ALU_A        = sel_a_s;
    bus.ALU_B        = sel_b_s;
    tag_in_s.valid   = gnt0_s | gnt1_s;
    tag_in_s.id      = gnt1_s;
    tag_in_s.err     = (gnt0_s | gnt1_s) & !is_legal_op(sel_op_s);
  end

  alu_arb_tag_pipe #(.DEPTH(ALU_LAT)) u_tag_pipe (
    .CK_REF   (CK_REF),
    .clr      (RST | FLUSH),
    .tag_in   (tag_in_s),
    .tag_tail (tag_tail_s)
  );

  // Response routing from the tail tag; the data bus reads zero unless a
  // legal operation is completing.
  always_comb begin
    rsp_live_s     = tag_tail_s.valid && !RST;
    bus.RSP0_VALID = rsp_live_s && !tag_tail_s.id;
    bus.RSP1_VALID = rsp_live_s && tag_tail_s.id;
    bus.RSP_ERR    = rsp_live_s && tag_tail_s.err;
    if (rsp_live_s && !tag_tail_s.err) begin
      bus.RSP_OUT   = bus.ALU_OUT;
      bus.RSP_CARRY = bus.ALU_CARRY;
      bus.RSP_ZERO  = bus.ALU_ZERO;
    end else begin
      bus.RSP_OUT   = '0;
      bus.RSP_CARRY = 1'b0;
      bus.RSP_ZERO  = 1'b0;
    end
  end

  alu_arbiter_chk u_chk (
    .CK_REF     (CK_REF),
    .RST        (RST),
    .tail_valid (tag_tail_s.valid),
    .tail_err   (tag_tail_s.err),
    .ALU_DONE   (bus.ALU_DONE)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a two-stage ALU model attached.
// Honours ALU_ARB_ROUND_ROBIN_EN for the arbitration expectations.
module tb_alu_arbiter;

  localparam int DW = 32;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic CK_REF = 1'b0;
  logic RST;
  logic FLUSH;
  int   total = 0;
  int   bad   = 0;

  alu_arbiter_if #(.DATA_W(DW)) bus ();

  alu_arbiter #(.DATA_W(DW), .ALU_LAT(2)) dut (
    .CK_REF (CK_REF),
    .RST    (RST),
    .FLUSH  (FLUSH),
    .bus    (bus)
  );

  always #5 CK_REF = ~CK_REF;

  // Two-stage ALU model: result visible two cycles after the issue cycle.
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    case (op)
      4'b0001: r = {1'b0, a} + {1'b0, b};
      4'b0010: r = {1'b0, a - b};
      4'b0011: r = {32'd0, ($signed(a) < $signed(b))};
      4'b1011: r = {32'd0, (a < b)};
      4'b0100: r = {1'b0, a & b};
      4'b0101: r = {1'b0, a | b};
      4'b0110: r = {1'b0, a ^ b};
      4'b0111: r = {1'b0, a << b[4:0]};
      4'b1000: r = {1'b0, a >> b[4:0]};
      4'b1001: r = {1'b0, $signed(a) >>> b[4:0]};
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  logic [32:0] s1_r = 33'd0, s2_r = 33'd0;
  logic        d1_r = 1'b0,  d2_r = 1'b0;

  always @(posedge CK_REF) begin
    s1_r <= alu_f(bus.ALU_OP_VAL, bus.ALU_A, bus.ALU_B);
    d1_r <= (bus.ALU_OP_VAL != 4'b0000);
    s2_r <= s1_r;
    d2_r <= d1_r;
  end

  assign bus.ALU_OUT   = s2_r[31:0];
  assign bus.ALU_CARRY = s2_r[32];
  assign bus.ALU_ZERO  = (s2_r[31:0] == 32'd0);
  assign bus.ALU_DONE  = d2_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    bus.REQ0_VALID = v0; bus.REQ0_OP = op0; bus.REQ0_A = a0; bus.REQ0_B = b0;
    bus.REQ1_VALID = v1; bus.REQ1_OP = op1; bus.REQ1_A = a1; bus.REQ1_B = b1;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0;
    bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
    bus.REQ0_OP = 4'b0000; bus.REQ1_OP = 4'b0000;
    bus.REQ0_A = 32'd0; bus.REQ0_B = 32'd0; bus.REQ1_A = 32'd0; bus.REQ1_B = 32'd0;

    // Reset: no grant even with a request pending, all outputs quiet.
    @(negedge CK_REF); idle();
    @(negedge CK_REF); drv(1'b1, 4'b0001, 32'd1, 32'd1, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk("rst_ready0", {31'd0, bus.REQ0_READY}, 32'd0);
    chk("rst_ready1", {31'd0, bus.REQ1_READY}, 32'd0);
    chk("rst_aluop",  {28'd0, bus.ALU_OP_VAL}, 32'd0);
    chk("rst_rsp0",   {31'd0, bus.RSP0_VALID}, 32'd0);
    chk("rst_rsp1",   {31'd0, bus.RSP1_VALID}, 32'd0);
    chk("rst_err",    {31'd0, bus.RSP_ERR},    32'd0);
    chk("rst_out",    bus.RSP_OUT,             32'd0);

    // ADD 5+7 from requester 0.
    @(negedge CK_REF); RST = 1'b0; drv(1'b1, 4'b0001, 32'd5, 32'd7, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk("add_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    chk("add_ready1", {31'd0, bus.REQ1_READY}, 32'd0);
    chk("add_aluop",  {28'd0, bus.ALU_OP_VAL}, 32'd1);
    chk("add_alua",   bus.ALU_A, 32'd5);
    chk("add_alub",   bus.ALU_B, 32'd7);
    @(negedge CK_REF); idle();
    chk("add_rsp_early", {31'd0, bus.RSP0_VALID}, 32'd0);
    chk("idle_alua",     bus.ALU_A, 32'd0);
    @(negedge CK_REF); idle();
    chk("add_rsp0",  {31'd0, bus.RSP0_VALID}, 32'd1);
    chk("add_rsp1",  {31'd0, bus.RSP1_VALID}, 32'd0);
    chk("add_out",   bus.RSP_OUT, 32'd12);
    chk("add_zero",  {31'd0, bus.RSP_ZERO}, 32'd0);
    chk("add_carry", {31'd0, bus.RSP_CARRY}, 32'd0);

    // Back-to-back: REQ1 SUB 3-3, then REQ0 SLTU 1<2.
    @(negedge CK_REF); drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 4'b0010, 32'd3, 32'd3);
    chk("sub_ready1", {31'd0, bus.REQ1_READY}, 32'd1);
    chk("add_rsp_once", {31'd0, bus.RSP0_VALID}, 32'd0);
    @(negedge CK_REF); drv(1'b1, 4'b1011, 32'd1, 32'd2, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk("sltu_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    chk("sltu_aluop",  {28'd0, bus.ALU_OP_VAL}, 32'hB);
    @(negedge CK_REF); idle();
    chk("sub_rsp1", {31'd0, bus.RSP1_VALID}, 32'd1);
    chk("sub_rsp0", {31'd0, bus.RSP0_VALID}, 32'd0);
    chk("sub_out",  bus.RSP_OUT, 32'd0);
    chk("sub_zero", {31'd0, bus.RSP_ZERO}, 32'd1);
    @(negedge CK_REF); idle();
    chk("sltu_rsp0", {31'd0, bus.RSP0_VALID}, 32'd1);
    chk("sltu_rsp1", {31'd0, bus.RSP1_VALID}, 32'd0);
    chk("sltu_out",  bus.RSP_OUT, 32'd1);

    // Illegal opcode 1111: accepted, ALU idle, error response.
    @(negedge CK_REF); drv(1'b1, 4'b1111, 32'd9, 32'd9, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk("ill_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    chk("ill_aluop",  {28'd0, bus.ALU_OP_VAL}, 32'd0);
    @(negedge CK_REF); idle();
    @(negedge CK_REF); idle();
    chk("ill_rsp0", {31'd0, bus.RSP0_VALID}, 32'd1);
    chk("ill_err",  {31'd0, bus.RSP_ERR}, 32'd1);
    chk("ill_out",  bus.RSP_OUT, 32'd0);

    // Carry out: REQ1 ADD 0xFFFFFFFF + 1.
    @(negedge CK_REF); drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 4'b0001, 32'hFFFF_FFFF, 32'd1);
    chk("cy_ready1", {31'd0, bus.REQ1_READY}, 32'd1);
    chk("cy_err_clear", {31'd0, bus.RSP_ERR}, 32'd0);
    @(negedge CK_REF); idle();
    @(negedge CK_REF); idle();
    chk("cy_rsp1",  {31'd0, bus.RSP1_VALID}, 32'd1);
    chk("cy_out",   bus.RSP_OUT, 32'd0);
    chk("cy_carry", {31'd0, bus.RSP_CARRY}, 32'd1);
    chk("cy_zero",  {31'd0, bus.RSP_ZERO}, 32'd1);

    // FLUSH the cycle after an issue, with REQ1 pending.
    @(negedge CK_REF); drv(1'b1, 4'b0001, 32'd1, 32'd1, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk("fl_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    @(negedge CK_REF); FLUSH = 1'b1; drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 4'b0101, 32'hF0, 32'h0F);
    chk("fl_ready1_blocked", {31'd0, bus.REQ1_READY}, 32'd0);
    chk("fl_aluop",          {28'd0, bus.ALU_OP_VAL}, 32'd0);
    @(negedge CK_REF); FLUSH = 1'b0; drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 4'b0101, 32'hF0, 32'h0F);
    chk("fl_ready1_after", {31'd0, bus.REQ1_READY}, 32'd1);
    chk("fl_no_rsp0",      {31'd0, bus.RSP0_VALID}, 32'd0);
    chk("fl_no_rsp1",      {31'd0, bus.RSP1_VALID}, 32'd0);
    @(negedge CK_REF); idle();
    chk("fl_quiet0", {31'd0, bus.RSP0_VALID}, 32'd0);
    @(negedge CK_REF); idle();
    chk("or_rsp1", {31'd0, bus.RSP1_VALID}, 32'd1);
    chk("or_out",  bus.RSP_OUT, 32'hFF);

    // Reset one cycle after an issue: no response, pointer back to requester 0.
    @(negedge CK_REF); drv(1'b1, 4'b0001, 32'd2, 32'd2, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk("mr_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    @(negedge CK_REF); RST = 1'b1; idle();
    @(negedge CK_REF); RST = 1'b0; drv(1'b1, 4'b0110, 32'd6, 32'd3, 1'b1, 4'b0100, 32'd6, 32'd3);
    chk("mr_no_rsp0", {31'd0, bus.RSP0_VALID}, 32'd0);
    chk("arb0_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    chk("arb0_ready1", {31'd0, bus.REQ1_READY}, 32'd0);

    // Both valid for three more cycles: round-robin alternates, fixed stays on 0.
    @(negedge CK_REF); drv(1'b1, 4'b0110, 32'd6, 32'd3, 1'b1, 4'b0100, 32'd6, 32'd3);
    chk("arb1_ready0", {31'd0, bus.REQ0_READY}, {31'd0, !RR});
    chk("arb1_ready1", {31'd0, bus.REQ1_READY}, {31'd0, RR});
    @(negedge CK_REF); drv(1'b1, 4'b0110, 32'd6, 32'd3, 1'b1, 4'b0100, 32'd6, 32'd3);
    chk("arb2_ready0", {31'd0, bus.REQ0_READY}, 32'd1);
    chk("arb2_ready1", {31'd0, bus.REQ1_READY}, 32'd0);
    chk("xor_rsp0",    {31'd0, bus.RSP0_VALID}, 32'd1);
    chk("xor_out",     bus.RSP_OUT, 32'd5);
    @(negedge CK_REF); drv(1'b1, 4'b0110, 32'd6, 32'd3, 1'b1, 4'b0100, 32'd6, 32'd3);
    chk("arb3_ready0", {31'd0, bus.REQ0_READY}, {31'd0, !RR});
    chk("arb3_ready1", {31'd0, bus.REQ1_READY}, {31'd0, RR});
    chk("arb_rsp1",    {31'd0, bus.RSP1_VALID}, {31'd0, RR});
    chk("arb_out",     bus.RSP_OUT, RR ? 32'd2 : 32'd5);

    // REQ0 drops: REQ1 is finally granted under either policy.
    @(negedge CK_REF); drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 4'b0100, 32'd6, 32'd3);
    chk("arb4_ready1", {31'd0, bus.REQ1_READY}, 32'd1);
    chk("arb4_ready0", {31'd0, bus.REQ0_READY}, 32'd0);

    @(negedge CK_REF); idle();
    @(negedge CK_REF); idle();
    @(negedge CK_REF); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
